// File: rtl/tlul_host_arb_pkg.sv
// Shared types for the Ibex two-host TL-UL arbiter: host tags, grant FSM states,
// a minimal TL-UL channel pair and the outstanding-counter width helper.
package tlul_host_arb_pkg;

    localparam int unsigned TlAiw = 8;
    localparam int unsigned TlAw  = 32;
    localparam int unsigned TlDw  = 32;

    localparam int unsigned MaxOutstandingDefault = 2;

    typedef enum logic {
        HostInstr = 1'b0,
        HostData  = 1'b1
    } host_e;

    typedef enum logic {
        ArbIdle,
        ArbLocked
    } arb_state_e;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [1:0]        a_size;
        logic [TlAiw-1:0]  a_source;
        logic [TlAw-1:0]   a_address;
        logic [TlDw/8-1:0] a_mask;
        logic [TlDw-1:0]   a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic             d_valid;
        logic [2:0]       d_opcode;
        logic [2:0]       d_param;
        logic [1:0]       d_size;
        logic [TlAiw-1:0] d_source;
        logic             d_sink;
        logic [TlDw-1:0]  d_data;
        logic             d_error;
        logic             a_ready;
    } tl_d2h_t;

    function automatic int unsigned cnt_w(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    localparam int unsigned CntWDefault = cnt_w(MaxOutstandingDefault);

endpackage

// File: rtl/tlul_host_arb_cnt.sv
// Per-host outstanding-transaction counter; simultaneous inc and dec leave it unchanged.
module tlul_host_arb_cnt
    import tlul_host_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = MaxOutstandingDefault,
    parameter int unsigned CntW           = cnt_w(MaxOutstanding)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({inc_i, dec_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o  = (cnt_q == CntW'(MaxOutstanding));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/tlul_ibex_host_arb.sv
// Merges the Ibex instruction and data TL-UL hosts onto one host port, tagging the source MSB.
// Define TLUL_HOST_ARB_RR_EN for round-robin arbitration; default is fixed priority data > instr.
module tlul_ibex_host_arb
    import tlul_host_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = MaxOutstandingDefault,
    parameter int unsigned SrcTagBit      = TlAiw - 1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_ih_i,
    output tl_d2h_t tl_ih_o,
    input  tl_h2d_t tl_dh_i,
    output tl_d2h_t tl_dh_o,
    output tl_h2d_t tl_h_o,
    input  tl_d2h_t tl_h_i,
    output logic    idle_o,
    output logic    err_o
);

    logic       full_i, full_d, empty_i, empty_d;
    logic       elig_i, elig_d;
    host_e      gnt_host;
    logic       gnt_valid;
    logic       a_hs;
    tl_h2d_t    req;
    arb_state_e state_d, state_q;
    host_e      lock_host_d, lock_host_q;
    host_e      d_host;
    logic       d_matched;
    logic       d_hs_i, d_hs_d;
    logic       err_d, err_q;
    tl_d2h_t    d_rsp;

    assign elig_i = tl_ih_i.a_valid & ~full_i;
    assign elig_d = tl_dh_i.a_valid & ~full_d;

`ifdef TLUL_HOST_ARB_RR_EN
    host_e rr_ptr_d, rr_ptr_q;

    assign rr_ptr_d = a_hs ? ((gnt_host == HostData) ? HostInstr : HostData) : rr_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= HostInstr;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // A locked grant keeps the A channel stable until the fabric accepts it.
    always_comb begin
        gnt_host = HostInstr;
        if (state_q == ArbLocked) begin
            gnt_host = lock_host_q;
        end else begin
`ifdef TLUL_HOST_ARB_RR_EN
            if (elig_i && elig_d) begin
                gnt_host = rr_ptr_q;
            end else if (elig_d) begin
                gnt_host = HostData;
            end else begin
                gnt_host = HostInstr;
            end
`else
            gnt_host = elig_d ? HostData : HostInstr;
`endif
        end
        gnt_valid = (gnt_host == HostData) ? elig_d : elig_i;
    end

    assign req  = (gnt_host == HostData) ? tl_dh_i : tl_ih_i;
    assign a_hs = gnt_valid & tl_h_i.a_ready;

    always_comb begin
        state_d     = state_q;
        lock_host_d = lock_host_q;
        unique case (state_q)
            ArbIdle: begin
                if (gnt_valid && !tl_h_i.a_ready) begin
                    state_d     = ArbLocked;
                    lock_host_d = gnt_host;
                end
            end
            ArbLocked: begin
                if (a_hs || !gnt_valid) begin
                    state_d = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ArbIdle;
            lock_host_q <= HostInstr;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_host_q <= lock_host_d;
            err_q       <= err_d;
        end
    end

    // D routing: a beat tagged for a host with nothing in flight is sunk and flagged.
    assign d_host    = tl_h_i.d_source[SrcTagBit] ? HostData : HostInstr;
    assign d_matched = (d_host == HostData) ? ~empty_d : ~empty_i;
    assign d_hs_i    = tl_h_i.d_valid & d_matched & (d_host == HostInstr) & tl_ih_i.d_ready;
    assign d_hs_d    = tl_h_i.d_valid & d_matched & (d_host == HostData) & tl_dh_i.d_ready;

    always_comb begin
        d_rsp                     = tl_h_i;
        d_rsp.d_source[SrcTagBit] = 1'b0;
        d_rsp.a_ready             = 1'b0;
        d_rsp.d_valid             = 1'b0;

        tl_ih_o         = d_rsp;
        tl_ih_o.d_valid = rst_ni & tl_h_i.d_valid & d_matched & (d_host == HostInstr);
        tl_ih_o.a_ready = rst_ni & a_hs & (gnt_host == HostInstr);

        tl_dh_o         = d_rsp;
        tl_dh_o.d_valid = rst_ni & tl_h_i.d_valid & d_matched & (d_host == HostData);
        tl_dh_o.a_ready = rst_ni & a_hs & (gnt_host == HostData);

        tl_h_o                     = req;
        tl_h_o.a_source[SrcTagBit] = gnt_host;
        tl_h_o.a_valid             = rst_ni & gnt_valid;
        if (!d_matched) begin
            tl_h_o.d_ready = rst_ni;
        end else if (d_host == HostData) begin
            tl_h_o.d_ready = rst_ni & tl_dh_i.d_ready;
        end else begin
            tl_h_o.d_ready = rst_ni & tl_ih_i.d_ready;
        end
    end

    assign err_d = err_q | (tl_h_i.d_valid & ~d_matched) | (a_hs & req.a_source[SrcTagBit]);

    tlul_host_arb_cnt #(
        .MaxOutstanding(MaxOutstanding)
    ) u_cnt_instr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (a_hs & (gnt_host == HostInstr)),
        .dec_i  (d_hs_i),
        .full_o (full_i),
        .empty_o(empty_i)
    );

    tlul_host_arb_cnt #(
        .MaxOutstanding(MaxOutstanding)
    ) u_cnt_data (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (a_hs & (gnt_host == HostData)),
        .dec_i  (d_hs_d),
        .full_o (full_d),
        .empty_o(empty_d)
    );

    assign idle_o = empty_i & empty_d;
    assign err_o  = err_q;

endmodule

// File: tb/tb_tlul_ibex_host_arb.sv
// Self-checking bench for tlul_ibex_host_arb: combinational vector table, A-channel scoreboard
// and hand-written sequences for stalls, grant lock, unmatched D beats and reset.
module tb_tlul_ibex_host_arb;
    import tlul_host_arb_pkg::*;

    logic    clk_i = 1'b0;
    logic    rst_ni;
    tl_h2d_t tl_ih_i, tl_dh_i, tl_h_o;
    tl_d2h_t tl_ih_o, tl_dh_o, tl_h_i;
    logic    idle_o, err_o;

    int checks   = 0;
    int failures = 0;

`ifdef TLUL_HOST_ARB_RR_EN
    localparam bit FirstData = 1'b0;
`else
    localparam bit FirstData = 1'b1;
`endif

    typedef struct {
        logic [7:0]  src;
        logic [31:0] addr;
    } exp_a_t;
    exp_a_t exp_q[$];

    typedef struct {
        logic        iv;
        logic        dv;
        logic [7:0]  isrc;
        logic [7:0]  dsrc;
        logic        fab_rdy;
        logic        exp_hv;
        logic [7:0]  exp_src;
        logic [31:0] exp_addr;
        logic        exp_ir;
        logic        exp_dr;
    } vec_t;
    vec_t vecs[6];

    tlul_ibex_host_arb dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tl_ih_i(tl_ih_i),
        .tl_ih_o(tl_ih_o),
        .tl_dh_i(tl_dh_i),
        .tl_dh_o(tl_dh_o),
        .tl_h_o (tl_h_o),
        .tl_h_i (tl_h_i),
        .idle_o (idle_o),
        .err_o  (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] s, input logic [31:0] a);
        exp_a_t e;
        e.src  = s;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic d_beat(input logic [7:0] src);
        tl_h_i.d_valid  = 1'b1;
        tl_h_i.d_source = src;
        tick();
        tl_h_i.d_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        tl_ih_i         = '0;
        tl_dh_i         = '0;
        tl_h_i          = '0;
        tl_ih_i.d_ready = 1'b1;
        tl_dh_i.d_ready = 1'b1;
        tl_h_i.a_ready  = 1'b1;
    endtask

    // Scoreboard: every accepted A beat on the merged port must match the next expected one.
    always @(negedge clk_i) begin
        exp_a_t e;
        if (rst_ni === 1'b1 && tl_h_o.a_valid === 1'b1 && tl_h_i.a_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("a_unexpected", 64'(tl_h_o.a_source), 64'hdead);
            end else begin
                e = exp_q.pop_front();
                chk("a_source", 64'(tl_h_o.a_source), 64'(e.src));
                chk("a_address", 64'(tl_h_o.a_address), 64'(e.addr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b1, 8'h05, 32'h1000_0005, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h03, 1'b1, 1'b1, 8'h83, 32'h2000_0003, 1'b0, 1'b1};
        if (FirstData) begin
            vecs[3] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b1, 1'b1, 8'h82, 32'h2000_0002, 1'b0, 1'b1};
            vecs[4] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 8'h82, 32'h2000_0002, 1'b0, 1'b0};
        end else begin
            vecs[3] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b1, 1'b1, 8'h01, 32'h1000_0001, 1'b1, 1'b0};
            vecs[4] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 8'h01, 32'h1000_0001, 1'b0, 1'b0};
        end
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h07, 1'b0, 1'b1, 8'h87, 32'h2000_0007, 1'b0, 1'b0};

        // Reset state, with a request pending to prove outputs are held low.
        idle_inputs();
        rst_ni          = 1'b0;
        tl_dh_i.a_valid = 1'b1;
        #3;
        chk("rst_idle", 64'(idle_o), 64'd1);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_h_a_valid", 64'(tl_h_o.a_valid), 64'd0);
        chk("rst_dh_a_ready", 64'(tl_dh_o.a_ready), 64'd0);
        chk("rst_h_d_ready", 64'(tl_h_o.d_ready), 64'd0);
        tl_dh_i.a_valid = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();

        // Combinational A mux from the empty state; valids drop before the edge.
        for (int i = 0; i < 6; i++) begin
            tl_ih_i.a_valid   = vecs[i].iv;
            tl_ih_i.a_source  = vecs[i].isrc;
            tl_ih_i.a_address = 32'h1000_0000 + 32'(vecs[i].isrc);
            tl_dh_i.a_valid   = vecs[i].dv;
            tl_dh_i.a_source  = vecs[i].dsrc;
            tl_dh_i.a_address = 32'h2000_0000 + 32'(vecs[i].dsrc);
            tl_h_i.a_ready    = vecs[i].fab_rdy;
            #3;
            chk($sformatf("vec%0d_h_valid", i), 64'(tl_h_o.a_valid), 64'(vecs[i].exp_hv));
            chk($sformatf("vec%0d_ih_ready", i), 64'(tl_ih_o.a_ready), 64'(vecs[i].exp_ir));
            chk($sformatf("vec%0d_dh_ready", i), 64'(tl_dh_o.a_ready), 64'(vecs[i].exp_dr));
            if (vecs[i].exp_hv) begin
                chk($sformatf("vec%0d_src", i), 64'(tl_h_o.a_source), 64'(vecs[i].exp_src));
                chk($sformatf("vec%0d_addr", i), 64'(tl_h_o.a_address), 64'(vecs[i].exp_addr));
            end
            tl_ih_i.a_valid = 1'b0;
            tl_dh_i.a_valid = 1'b0;
            tl_h_i.a_ready  = 1'b1;
            tick();
        end
        idle_inputs();

        // Data-only stream: two issue, third stalls until a D beat frees a slot.
        tl_dh_i.a_valid   = 1'b1;
        tl_dh_i.a_address = 32'h2000_0100;
        push(8'h80, 32'h2000_0100);
        tick();
        tl_dh_i.a_address = 32'h2000_0104;
        push(8'h80, 32'h2000_0104);
        tick();
        tl_dh_i.a_address = 32'h2000_0108;
        #3;
        chk("stall_dh_a_ready", 64'(tl_dh_o.a_ready), 64'd0);
        chk("stall_h_a_valid", 64'(tl_h_o.a_valid), 64'd0);
        tick();
        tick();
        tl_h_i.d_valid  = 1'b1;
        tl_h_i.d_source = 8'h80;
        #3;
        chk("d_route_dh_valid", 64'(tl_dh_o.d_valid), 64'd1);
        chk("d_route_dh_source", 64'(tl_dh_o.d_source), 64'h00);
        chk("d_route_ih_valid", 64'(tl_ih_o.d_valid), 64'd0);
        chk("d_route_h_ready", 64'(tl_h_o.d_ready), 64'd1);
        chk("stall_during_d", 64'(tl_dh_o.a_ready), 64'd0);
        push(8'h80, 32'h2000_0108);
        tick();
        tl_h_i.d_valid = 1'b0;
        #3;
        chk("unstall_dh_a_ready", 64'(tl_dh_o.a_ready), 64'd1);
        tick();
        tl_dh_i.a_valid = 1'b0;
        chk("stream_busy", 64'(idle_o), 64'd0);
        d_beat(8'h80);
        d_beat(8'h80);
        chk("stream_idle", 64'(idle_o), 64'd1);

        // Simultaneous requests from both hosts.
        tl_ih_i.a_valid   = 1'b1;
        tl_ih_i.a_source  = 8'h11;
        tl_ih_i.a_address = 32'h1000_0200;
        tl_dh_i.a_valid   = 1'b1;
        tl_dh_i.a_source  = 8'h22;
        tl_dh_i.a_address = 32'h2000_0200;
        if (FirstData) begin
            push(8'hA2, 32'h2000_0200);
            push(8'h11, 32'h1000_0200);
        end else begin
            push(8'h11, 32'h1000_0200);
            push(8'hA2, 32'h2000_0200);
        end
        #3;
        chk("tie_first_dh", 64'(tl_dh_o.a_ready), 64'(FirstData));
        chk("tie_first_ih", 64'(tl_ih_o.a_ready), 64'(!FirstData));
        tick();
        if (FirstData) tl_dh_i.a_valid = 1'b0;
        else tl_ih_i.a_valid = 1'b0;
        #3;
        chk("tie_second_dh", 64'(tl_dh_o.a_ready), 64'(!FirstData));
        chk("tie_second_ih", 64'(tl_ih_o.a_ready), 64'(FirstData));
        tick();
        tl_ih_i.a_valid = 1'b0;
        tl_dh_i.a_valid = 1'b0;
        d_beat(8'h80);
        d_beat(8'h00);
        chk("tie_idle", 64'(idle_o), 64'd1);

        // Grant lock: data is stalled by the fabric while instr also requests.
        tl_h_i.a_ready    = 1'b0;
        tl_dh_i.a_valid   = 1'b1;
        tl_dh_i.a_source  = 8'h01;
        tl_dh_i.a_address = 32'h2000_0300;
        push(8'h81, 32'h2000_0300);
        tick();
        tl_ih_i.a_valid   = 1'b1;
        tl_ih_i.a_source  = 8'h02;
        tl_ih_i.a_address = 32'h1000_0300;
        push(8'h02, 32'h1000_0300);
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("lock%0d_valid", c), 64'(tl_h_o.a_valid), 64'd1);
            chk($sformatf("lock%0d_src", c), 64'(tl_h_o.a_source), 64'h81);
            chk($sformatf("lock%0d_addr", c), 64'(tl_h_o.a_address), 64'h2000_0300);
            tick();
        end
        tl_h_i.a_ready = 1'b1;
        #3;
        chk("lock_release_dh", 64'(tl_dh_o.a_ready), 64'd1);
        chk("lock_release_ih", 64'(tl_ih_o.a_ready), 64'd0);
        tick();
        tl_dh_i.a_valid = 1'b0;
        #3;
        chk("lock_next_ih", 64'(tl_ih_o.a_ready), 64'd1);
        tick();
        tl_ih_i.a_valid = 1'b0;
        d_beat(8'h80);
        d_beat(8'h00);

        // Same-cycle A and D handshake on the data host keeps its count at one.
        tl_dh_i.a_valid   = 1'b1;
        tl_dh_i.a_source  = 8'h00;
        tl_dh_i.a_address = 32'h2000_0400;
        push(8'h80, 32'h2000_0400);
        tick();
        tl_dh_i.a_address = 32'h2000_0404;
        push(8'h80, 32'h2000_0404);
        tl_h_i.d_valid  = 1'b1;
        tl_h_i.d_source = 8'h80;
        #3;
        chk("same_cycle_a_ready", 64'(tl_dh_o.a_ready), 64'd1);
        chk("same_cycle_d_valid", 64'(tl_dh_o.d_valid), 64'd1);
        tick();
        tl_dh_i.a_valid = 1'b0;
        tl_h_i.d_valid  = 1'b0;
        chk("same_cycle_busy", 64'(idle_o), 64'd0);
        d_beat(8'h80);
        chk("same_cycle_idle", 64'(idle_o), 64'd1);
        chk("no_err_yet", 64'(err_o), 64'd0);

        // Unmatched D beat for the instruction host.
        tl_h_i.d_valid  = 1'b1;
        tl_h_i.d_source = 8'h00;
        #3;
        chk("unmatched_d_ready", 64'(tl_h_o.d_ready), 64'd1);
        chk("unmatched_ih_valid", 64'(tl_ih_o.d_valid), 64'd0);
        chk("unmatched_dh_valid", 64'(tl_dh_o.d_valid), 64'd0);
        tick();
        tl_h_i.d_valid = 1'b0;
        chk("unmatched_err", 64'(err_o), 64'd1);
        tick();
        tick();
        chk("unmatched_err_sticky", 64'(err_o), 64'd1);

        // Reset with two data transactions outstanding, then a late response.
        rst_ni = 1'b0;
        #1;
        chk("reset_clears_err", 64'(err_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        tl_dh_i.a_valid   = 1'b1;
        tl_dh_i.a_address = 32'h2000_0500;
        push(8'h80, 32'h2000_0500);
        tick();
        tl_dh_i.a_address = 32'h2000_0504;
        push(8'h80, 32'h2000_0504);
        tick();
        tl_dh_i.a_valid = 1'b0;
        chk("pre_reset_busy", 64'(idle_o), 64'd0);
        #3;
        rst_ni          = 1'b0;
        tl_dh_i.a_valid = 1'b1;
        #1;
        chk("mid_reset_idle", 64'(idle_o), 64'd1);
        chk("mid_reset_h_valid", 64'(tl_h_o.a_valid), 64'd0);
        chk("mid_reset_dh_ready", 64'(tl_dh_o.a_ready), 64'd0);
        tl_dh_i.a_valid = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_reset_err", 64'(err_o), 64'd0);
        tl_h_i.d_valid  = 1'b1;
        tl_h_i.d_source = 8'h80;
        #3;
        chk("late_dh_valid", 64'(tl_dh_o.d_valid), 64'd0);
        chk("late_h_d_ready", 64'(tl_h_o.d_ready), 64'd1);
        tick();
        tl_h_i.d_valid = 1'b0;
        chk("late_err", 64'(err_o), 64'd1);

        // Host driving the tag bit: forwarded with its own tag, error flagged.
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        tl_ih_i.a_valid   = 1'b1;
        tl_ih_i.a_source  = 8'h80;
        tl_ih_i.a_address = 32'h1000_0600;
        push(8'h00, 32'h1000_0600);
        #3;
        chk("tagbit_err_before", 64'(err_o), 64'd0);
        tick();
        tl_ih_i.a_valid = 1'b0;
        chk("tagbit_err", 64'(err_o), 64'd1);
        d_beat(8'h00);
        chk("tagbit_idle", 64'(idle_o), 64'd1);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
